// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 add/sub datapath between two requesters.
// Define FP_ARB_STATS_EN to build the saturating per-requester grant counters.
module fp_addsub_arbiter #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_exception,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic             dp_sub,
  input  logic [31:0]      dp_result,
  input  logic             dp_exception,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic       ptr;
  logic       owner;
  logic [3:0] cnt;
  logic       grant0;
  logic       grant1;
  logic       rsp_take;

  // A lone requester always wins; on contention the pointer decides.
  assign grant0     = req0_valid && (!req1_valid || !ptr);
  assign grant1     = req1_valid && (!req0_valid || ptr);
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      cnt           <= '0;
      dp_a          <= '0;
      dp_b          <= '0;
      dp_sub        <= 1'b0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            dp_a   <= req1_ready ? req1_a   : req0_a;
            dp_b   <= req1_ready ? req1_b   : req0_b;
            dp_sub <= req1_ready ? req1_sub : req0_sub;
            owner  <= req1_ready;
            ptr    <= !req1_ready;
            cnt    <= CNT_INIT;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result    <= dp_result;
            rsp_exception <= dp_exception;
            rsp0_valid    <= !owner;
            rsp1_valid    <= owner;
            state         <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_ONE;
      if (req1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_ONE;
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: behavioural arbiter model plus directed vectors on
// LATENCY=1 and LATENCY=4 instances, each with a real-arithmetic datapath stand-in.
module tb_fp_addsub_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result, dp_a, dp_b, dp_result;
  logic        rsp_exception, dp_sub, dp_exception;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic [32:0] dp_out;

  logic        l4_req0_valid, l4_req0_ready, l4_req1_ready;
  logic [31:0] l4_req0_a, l4_req0_b;
  logic        l4_rsp0_valid, l4_rsp1_valid;
  logic [31:0] l4_rsp_result, l4_dp_a, l4_dp_b, l4_dp_result;
  logic        l4_rsp_exception, l4_dp_sub, l4_dp_exception;
  logic [15:0] l4_grant_cnt0, l4_grant_cnt1;
  logic [32:0] l4_dp_out;

  int checks = 0;
  int errors = 0;

  function automatic real bits2real(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    if (e > 0) for (int i = 0; i < e; i++) v = v * 2.0;
    else       for (int i = 0; i < -e; i++) v = v / 2.0;
    return f[31] ? -v : v;
  endfunction

  // {exception, result}; non-finite operands flag an exception with a quiet NaN.
  function automatic logic [32:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real    r;
    logic   s;
    int     e;
    longint m;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {1'b1, 32'h7FC00000};
    r = bits2real(a) + (sub ? -bits2real(b) : bits2real(b));
    if (r == 0.0) return 33'd0;
    s = (r < 0.0);
    if (s) r = -r;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    m = longint'((r - 1.0) * 8388608.0);
    return {1'b0, s, 8'(e), 23'(m)};
  endfunction

  assign dp_out          = fp_op(dp_a, dp_b, dp_sub);
  assign dp_result       = dp_out[31:0];
  assign dp_exception    = dp_out[32];
  assign l4_dp_out       = fp_op(l4_dp_a, l4_dp_b, l4_dp_sub);
  assign l4_dp_result    = l4_dp_out[31:0];
  assign l4_dp_exception = l4_dp_out[32];

  fp_addsub_arbiter #(.LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_result(dp_result), .dp_exception(dp_exception),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  fp_addsub_arbiter #(.LATENCY(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(l4_req0_valid), .req0_ready(l4_req0_ready), .req0_a(l4_req0_a), .req0_b(l4_req0_b), .req0_sub(1'b0),
    .req1_valid(1'b0), .req1_ready(l4_req1_ready), .req1_a(32'd0), .req1_b(32'd0), .req1_sub(1'b0),
    .rsp0_valid(l4_rsp0_valid), .rsp0_ready(1'b1), .rsp1_valid(l4_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_result(l4_rsp_result), .rsp_exception(l4_rsp_exception),
    .dp_a(l4_dp_a), .dp_b(l4_dp_b), .dp_sub(l4_dp_sub), .dp_result(l4_dp_result), .dp_exception(l4_dp_exception),
    .grant_cnt0(l4_grant_cnt0), .grant_cnt1(l4_grant_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for a grant, 1 = operation in flight, 2 = result offered.
  int          m_phase = 0;
  int          m_left = 0;
  bit          m_ptr = 1'b0;
  bit          m_owner = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  bit          m_sub = 1'b0;
  logic [32:0] m_res = '0;
  int          m_g0 = 0;
  int          m_g1 = 0;
  bit          e_r0, e_r1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctl", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_exception, dp_sub}), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_dp_ab", dp_a | dp_b, 32'd0);
      chk("rst_grant_cnt", 32'({grant_cnt0, grant_cnt1}), 32'd0);
      m_phase = 0;
      m_ptr   = 1'b0;
      m_g0    = 0;
      m_g1    = 0;
    end else begin
      e_r0 = (m_phase == 0) && req0_valid && (!req1_valid || !m_ptr);
      e_r1 = (m_phase == 0) && req1_valid && (!req0_valid || m_ptr);
      chk("req_ready", 32'({req0_ready, req1_ready}), 32'({e_r0, e_r1}));
      chk("rsp_valid", 32'({rsp0_valid, rsp1_valid}),
          32'({(m_phase == 2) && !m_owner, (m_phase == 2) && m_owner}));
      if (m_phase == 2) begin
        chk("rsp_result", rsp_result, m_res[31:0]);
        chk("rsp_exception", 32'(rsp_exception), 32'(m_res[32]));
      end
      if (m_phase != 0) begin
        chk("dp_a_hold", dp_a, m_a);
        chk("dp_b_hold", dp_b, m_b);
        chk("dp_sub_hold", 32'(dp_sub), 32'(m_sub));
      end
`ifdef FP_ARB_STATS_EN
      chk("grant_cnt0", 32'(grant_cnt0), 32'(m_g0));
      chk("grant_cnt1", 32'(grant_cnt1), 32'(m_g1));
`else
      chk("grant_cnt_tied", 32'({grant_cnt0, grant_cnt1}), 32'd0);
`endif
      case (m_phase)
        0: if (e_r0 || e_r1) begin
             m_owner = e_r1;
             m_a     = e_r1 ? req1_a : req0_a;
             m_b     = e_r1 ? req1_b : req0_b;
             m_sub   = e_r1 ? req1_sub : req0_sub;
             m_res   = fp_op(m_a, m_b, m_sub);
             m_ptr   = !e_r1;
             m_left  = LAT;
             m_phase = 1;
             if (e_r1) m_g1++; else m_g0++;
           end
        1: begin
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
      endcase
    end
  end

  // Entered at posedge+1; returns at posedge+1 after the handshake with valid dropped.
  task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b, input logic sub);
    bit got;
    got = 1'b0;
    if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = n ? req1_ready : req0_ready;
    end
    if (!got) begin errors++; checks++; $display("FAIL issue_timeout req%0d actual=0 expected=1", n); end
    @(posedge clk); #1;
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Counts cycles after the handshake cycle; returns at the negedge of the first response cycle.
  task automatic wait_rsp(input bit n, output int cyc, output logic [31:0] res);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i < 50 && !got; i++) begin
      @(negedge clk);
      cyc = i;
      got = n ? rsp1_valid : rsp0_valid;
    end
    if (!got) begin errors++; checks++; $display("FAIL rsp_timeout rsp%0d actual=0 expected=1", n); end
    res = rsp_result;
  endtask

  int          cyc;
  logic [31:0] res;
  int          order[$];
  int          idx0, idx1, grants, guard;
  bit          g0, g1, seen;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    l4_req0_valid = 1'b0; l4_req0_a = '0; l4_req0_b = '0;

    chk("model_1p2", fp_op(32'h3F800000, 32'h40000000, 1'b0)[31:0], 32'h40400000);
    chk("model_3m1", fp_op(32'h40400000, 32'h3F800000, 1'b1)[31:0], 32'h40000000);
    chk("model_5p5", fp_op(32'h40A00000, 32'h40A00000, 1'b0)[31:0], 32'h41200000);

    // Fairness: both requesters valid from reset onward.
    idx0 = 0; idx1 = 1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    req1_valid = 1'b1; req1_a = 32'h3F900000; req1_b = 32'h40000000; req1_sub = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    grants = 0; guard = 0;
    while (grants < 6 && guard < 200) begin
      @(negedge clk);
      guard++;
      g0 = req0_ready; g1 = req1_ready;
      if (g0) begin order.push_back(0); grants++; end
      if (g1) begin order.push_back(1); grants++; end
      @(posedge clk); #1;
      if (g0) begin idx0 += 2; req0_a = 32'h3F800000 | 32'(idx0 << 20); end
      if (g1) begin idx1 += 2; req1_a = 32'h3F800000 | 32'(idx1 << 20); end
      if (grants >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; req1_sub = 1'b0;
    chk("grant_total", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) chk("grant_order", 32'(order[i]), 32'(i % 2));
    repeat (6) @(posedge clk);
`ifdef FP_ARB_STATS_EN
    chk("stats_cnt0", 32'(grant_cnt0), 32'd3);
    chk("stats_cnt1", 32'(grant_cnt1), 32'd3);
`endif
    #1;

    // Single requester 0: 1.0 + 2.0.
    issue(1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    wait_rsp(1'b0, cyc, res);
    chk("add_latency", 32'(cyc), 32'd2);
    chk("add_result", res, 32'h40400000);
    chk("add_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure on rsp0 while requester 1 waits; then requester 1: 3.0 - 1.0.
    rsp0_ready = 1'b0;
    issue(1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h3F800000; req1_sub = 1'b1;
    wait_rsp(1'b0, cyc, res);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      chk("bp_result_stable", rsp_result, 32'h40400000);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    chk("bp_req1_granted", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(1'b1, cyc, res);
    chk("sub_latency", 32'(cyc), 32'd2);
    chk("sub_result", res, 32'h40000000);
    chk("sub_dp_sub", 32'(dp_sub), 32'd1);
    @(posedge clk); #1;

    // Reset while the operation is in flight.
    req0_valid = 1'b1; req0_a = 32'h40A00000; req0_b = 32'h3F800000; req0_sub = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, dp_sub}), 32'd0);
    chk("async_rst_dp_a", dp_a, 32'd0);
    chk("async_rst_result", rsp_result, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000; req1_sub = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = req0_ready | req1_ready; end
    chk("post_rst_first_grant", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1 req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = req1_ready; end
    chk("post_rst_second_grant", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // LATENCY=4 instance: 5.0 + 5.0.
    l4_req0_valid = 1'b1; l4_req0_a = 32'h40A00000; l4_req0_b = 32'h40A00000;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = l4_req0_ready; end
    chk("l4_accept", 32'(seen), 32'd1);
    @(posedge clk); #1 l4_req0_valid = 1'b0; l4_req0_a = 32'hDEADBEEF; l4_req0_b = 32'h12345678;
    seen = 1'b0; cyc = 0;
    for (int i = 1; i < 30 && !seen; i++) begin
      @(negedge clk);
      cyc = i;
      chk("l4_dp_a_hold", l4_dp_a, 32'h40A00000);
      chk("l4_dp_b_hold", l4_dp_b, 32'h40A00000);
      seen = l4_rsp0_valid;
    end
    chk("l4_latency", 32'(cyc), 32'd5);
    chk("l4_result", l4_rsp_result, 32'h41200000);
    chk("l4_exception", 32'({l4_rsp_exception, l4_rsp1_valid}), 32'd0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Shares one 32-bit IEEE-754 add/sub datapath (the Addition_Subtraction unit) between two requesters.
- Round-robin arbitration with a valid/ready request channel and a valid/ready response channel per requester.
- Registers the operands onto the datapath, waits a programmable settle latency, then captures the result.
- Sits between the ALU front-end issue logic and the shared add/sub unit.

Parameters:
- LATENCY, 1: cycles from operand launch to result capture (legal range 1..15).
- CNT_W, 16: width of the optional grant counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand A.
- req0_b  in  32  requester 0 operand B.
- req0_sub  in  1  0 = add, 1 = subtract (AddBar_Sub encoding).
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result available for requester 1.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_result  out  32  shared result bus.
- rsp_exception  out  1  shared exception flag.
- dp_a  out  32  operand A to the datapath.
- dp_b  out  32  operand B to the datapath.
- dp_sub  out  1  add/sub select to the datapath.
- dp_result  in  32  datapath result.
- dp_exception  in  1  datapath exception.
- grant_cnt0  out  CNT_W  grants to requester 0 (optional feature).
- grant_cnt1  out  CNT_W  grants to requester 1 (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, priority pointer=0.
  - All outputs 0: ready, rsp_valid, rsp_result, rsp_exception, dp_*, grant counters.
  - An operation in flight is aborted; no response is produced after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only one requester valid: grant it. Both valid: grant the pointer's requester.
  - reqN_ready=1 only in IDLE and only for the granted requester. No ready is asserted when no request is valid.
  - On valid&ready: dp_a/dp_b/dp_sub <= granted operands; owner <= N; cnt <= LATENCY-1; pointer <= other requester; go to EXEC.
- EXEC:
  - cnt decrements each cycle.
  - When cnt==0: rsp_result <= dp_result, rsp_exception <= dp_exception; go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp_valid stays 0.
  - rsp_result and rsp_exception are held stable until rsp<owner>_ready=1, then go to IDLE.
  - Arbitrary backpressure is allowed.
- Latency: accept at edge T; rsp valid from edge T+LATENCY+1. Back-to-back throughput is one op per LATENCY+2 cycles with rsp_ready tied 1.
- dp_* are stable from launch through capture, and keep their last value afterwards. Nothing is driven combinationally from the request inputs.
- Requester rules:
  - Operands must be stable while valid && !ready.
  - Deasserting valid before grant is legal; the block keeps no record of it.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... starting with 0 after reset.
- A single active requester is granted every time, regardless of pointer.
- rsp_ready asserted outside RESP, or for the non-owner, is ignored.

Optional Feature:
- FP_ARB_STATS_EN defined:
  - grant_cnt0/1 increment on each accepted request of that requester.
  - Counters saturate at all-ones; reset to 0.
- FP_ARB_STATS_EN undefined:
  - Counter logic is absent; grant_cnt0/1 are tied to 0.
  - Ports remain present.

Test Plan:
- Bench connects the real add/sub unit, LATENCY=1. req0: a=0x3F800000, b=0x40000000, sub=0 -> rsp0_valid at accept+2 with rsp_result=0x40400000, rsp_exception=0; rsp1_valid stays 0.
- req1: a=0x40400000, b=0x3F800000, sub=1 -> rsp1 result 0x40000000; dp_sub=1 for the whole EXEC phase.
- Both valid continuously from reset, 6 ops, rsp_ready=1 -> grant order 0,1,0,1,0,1; each result returns on the correct rsp channel; with the feature on, grant_cnt0=3 and grant_cnt1=3.
- Hold rsp0_ready=0 for 5 cycles in RESP while req1_valid=1 -> req1_ready stays 0 and rsp_result is stable; after the rsp0 handshake, req1 is granted next cycle.
- Assert rst_n=0 during EXEC -> all outputs 0 immediately; no rsp_valid after release; the next request pair grants req0 first.
- LATENCY=4, req0 0x40A00000 + 0x40A00000 -> result 0x41200000 exactly 5 cycles after accept; dp_a/dp_b unchanged throughout.
